// File: rtl/lifo_stack_pkg.sv
// lifo_stack_pkg: {push,pop} operation codes and the count-width helper for lifo_stack
package lifo_stack_pkg;
  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_REPL = 2'b11;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/lifo_stack_mem.sv
// lifo_stack_mem: DEPTH x WIDTH register array with one synchronous write port and one asynchronous read port, no reset
module lifo_stack_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/lifo_stack.sv
// lifo_stack: parametrised LIFO with peek, replace-top, overflow/underflow pulses; LIFO_STACK_STICKY_ERR_EN makes error sticky until err_clr
module lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      err_clr,
  input  logic [WIDTH-1:0]          data_in,
  output logic [WIDTH-1:0]          data_out,
  output logic [WIDTH-1:0]          top,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      empty,
  output logic                      full,
  output logic                      overflow,
  output logic                      underflow,
  output logic                      error
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [1:0]       op;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] rd;
  logic             we;
  logic             ovf_n;
  logic             unf_n;
  assign op      = {push, pop};
  assign empty   = count == CW'(0);
  assign full    = count == CW'(DEPTH);
  assign top_idx = count[AW-1:0] - AW'(1);
  assign top     = empty ? '0 : rd;
  assign we      = (op == OP_PUSH && !full) || (op == OP_REPL && !empty);
  assign waddr   = op == OP_PUSH ? count[AW-1:0] : top_idx;
  assign ovf_n   = op == OP_PUSH && full;
  assign unf_n   = op == OP_POP && empty;
  lifo_stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(data_in),
    .raddr(top_idx),
    .rdata(rd)
  );
  always_ff @(posedge clk)
    if (reset) begin
      count     <= '0;
      data_out  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_n;
      underflow <= unf_n;
      count     <= op == OP_PUSH && !full ? count + CW'(1) :
                   op == OP_POP && !empty ? count - CW'(1) : count;
      data_out  <= op == OP_REPL && empty ? data_in :
                   (op == OP_REPL || op == OP_POP) && !empty ? rd : data_out;
    end
`ifdef LIFO_STACK_STICKY_ERR_EN
  logic err_r;
  always_ff @(posedge clk)
    if (reset) err_r <= 1'b0;
    else       err_r <= ovf_n || unf_n ? 1'b1 : err_clr ? 1'b0 : err_r;
  assign error = err_r;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign error = overflow | underflow;
`endif
endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: directed and randomized checks of two lifo_stack instances against a queue-based model
module tb_lifo_stack;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        push_a = 1'b0, pop_a = 1'b0, clr_a = 1'b0;
  logic [7:0]  din_a = '0;
  logic [7:0]  dout_a, top_a;
  logic [4:0]  cnt_a;
  logic        empty_a, full_a, ovf_a, unf_a, err_a;
  logic        push_b = 1'b0, pop_b = 1'b0, clr_b = 1'b0;
  logic [11:0] din_b = '0;
  logic [11:0] dout_b, top_b;
  logic [2:0]  cnt_b;
  logic        empty_b, full_b, ovf_b, unf_b, err_b;
  int total = 0;
  int bad = 0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [15:0] m_dout[2];
  bit          m_ovf[2], m_unf[2], m_err[2];

  always #5 clk = ~clk;

  lifo_stack #(.WIDTH(8), .DEPTH(16)) dut_a (
    .clk(clk), .reset(reset), .push(push_a), .pop(pop_a), .err_clr(clr_a),
    .data_in(din_a), .data_out(dout_a), .top(top_a), .count(cnt_a),
    .empty(empty_a), .full(full_a), .overflow(ovf_a), .underflow(unf_a), .error(err_a)
  );
  lifo_stack #(.WIDTH(12), .DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .push(push_b), .pop(pop_b), .err_clr(clr_b),
    .data_in(din_b), .data_out(dout_b), .top(top_b), .count(cnt_b),
    .empty(empty_b), .full(full_b), .overflow(ovf_b), .underflow(unf_b), .error(err_b)
  );

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic check(input int s);
    logic [15:0] q[$];
    int          dp;
    string       p;
    q  = s != 0 ? qb : qa;
    dp = s != 0 ? 4 : 16;
    p  = s != 0 ? "b" : "a";
    chk({p, ".count"}, s != 0 ? 16'(cnt_b) : 16'(cnt_a), 16'(q.size()));
    chk({p, ".empty"}, s != 0 ? 16'(empty_b) : 16'(empty_a), 16'(q.size() == 0));
    chk({p, ".full"}, s != 0 ? 16'(full_b) : 16'(full_a), 16'(q.size() == dp));
    chk({p, ".top"}, s != 0 ? 16'(top_b) : 16'(top_a), q.size() > 0 ? q[q.size()-1] : 16'h0);
    chk({p, ".data_out"}, s != 0 ? 16'(dout_b) : 16'(dout_a), m_dout[s]);
    chk({p, ".overflow"}, s != 0 ? 16'(ovf_b) : 16'(ovf_a), 16'(m_ovf[s]));
    chk({p, ".underflow"}, s != 0 ? 16'(unf_b) : 16'(unf_a), 16'(m_unf[s]));
    chk({p, ".error"}, s != 0 ? 16'(err_b) : 16'(err_a), 16'(m_err[s]));
  endtask

  task automatic do_reset(input bit hold_push);
    reset  = 1'b1;
    push_a = hold_push; pop_a = 1'b0; clr_a = 1'b0; din_a = 8'h5A;
    push_b = hold_push; pop_b = 1'b0; clr_b = 1'b0; din_b = 12'h5A5;
    @(posedge clk);
    #1 reset = 1'b0;
    qa.delete();
    qb.delete();
    for (int k = 0; k < 2; k++) begin
      m_dout[k] = '0; m_ovf[k] = 0; m_unf[k] = 0; m_err[k] = 0;
    end
    check(0);
    check(1);
  endtask

  task automatic do_op(input int s, input bit p, input bit o, input bit c, input logic [15:0] d);
    logic [15:0] q[$];
    logic [15:0] w;
    int          dp;
    int          t;
    q  = s != 0 ? qb : qa;
    dp = s != 0 ? 4 : 16;
    w  = s != 0 ? (d & 16'h0FFF) : (d & 16'h00FF);
    t  = 1 - s;
    push_a = s == 0 && p; pop_a = s == 0 && o; clr_a = s == 0 && c; din_a = d[7:0];
    push_b = s == 1 && p; pop_b = s == 1 && o; clr_b = s == 1 && c; din_b = d[11:0];
    @(posedge clk);
    m_ovf[s] = 0;
    m_unf[s] = 0;
    if (p && !o) begin
      if (q.size() < dp) q.push_back(w);
      else m_ovf[s] = 1;
    end else if (o && !p) begin
      if (q.size() > 0) m_dout[s] = q.pop_back();
      else m_unf[s] = 1;
    end else if (p && o) begin
      if (q.size() > 0) begin
        m_dout[s] = q[q.size()-1];
        q[q.size()-1] = w;
      end else m_dout[s] = w;
    end
    m_ovf[t] = 0;
    m_unf[t] = 0;
`ifdef LIFO_STACK_STICKY_ERR_EN
    m_err[s] = (m_ovf[s] || m_unf[s]) ? 1'b1 : c ? 1'b0 : m_err[s];
`else
    m_err[s] = m_ovf[s] || m_unf[s];
    m_err[t] = 0;
`endif
    if (s != 0) qb = q;
    else qa = q;
    #1;
    check(0);
    check(1);
  endtask

  initial begin
    do_reset(0);
    for (int i = 0; i < 16; i++) do_op(0, 1, 0, 0, 16'(i));
    chk("a.fill_top", 16'(top_a), 16'h000F);
    chk("a.fill_full", 16'(full_a), 16'h0001);
    do_op(0, 1, 0, 0, 16'h00AA);
    chk("a.ovf_pulse", 16'(ovf_a), 16'h0001);
    chk("a.ovf_err", 16'(err_a), 16'h0001);
    do_op(0, 1, 0, 0, 16'h00AB);
    do_op(0, 0, 0, 0, 16'h0);
    do_op(0, 0, 0, 0, 16'h0);
    do_op(0, 0, 0, 1, 16'h0);
    for (int i = 0; i < 16; i++) do_op(0, 0, 1, 0, 16'h0);
    chk("a.drain_last", 16'(dout_a), 16'h0000);
    do_op(0, 0, 1, 0, 16'h0);
    do_op(0, 0, 1, 1, 16'h0);
    do_op(0, 1, 0, 0, 16'h0011);
    do_op(0, 1, 1, 0, 16'h0022);
    chk("a.repl_out", 16'(dout_a), 16'h0011);
    chk("a.repl_top", 16'(top_a), 16'h0022);
    do_op(0, 0, 1, 0, 16'h0);
    do_op(0, 1, 1, 0, 16'h0033);
    chk("a.pass_out", 16'(dout_a), 16'h0033);
    for (int i = 0; i < 5; i++) do_op(0, 1, 0, 0, 16'h0040 + 16'(i));
    do_reset(1);
    for (int i = 0; i < 5; i++) do_op(1, 1, 0, 0, 16'hA00 + 16'(i));
    do_op(1, 1, 1, 0, 16'h0BCD);
    for (int i = 0; i < 5; i++) do_op(1, 0, 1, 0, 16'h0);
    do_op(1, 1, 1, 0, 16'h0777);
    for (int ph = 0; ph < 4; ph++) begin
      int pp;
      int po;
      pp = ph[0] ? 30 : 75;
      po = ph[0] ? 75 : 30;
      for (int n = 0; n < 150; n++)
        do_op(int'($urandom_range(0, 1)), $urandom_range(0, 99) < pp,
              $urandom_range(0, 99) < po, $urandom_range(0, 7) == 0, 16'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
